shift_add_accumulator: RTL and testbench
========================================

SHIFT_ADD_ACCUMULATOR -- requirements
Module: shift_add_accumulator

Interface
REQ-001 Parameter WORD_LENGTH, default 8, operand width in bits; the product is 2*WORD_LENGTH bits wide.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 multiplicandShifted  input  2*WORD_LENGTH  parallel output of the upstream left shift register (multiplicand, zero-extended, shifted left once per shift).
REQ-006 multiplierBit  input  1  serial LSB output of the upstream right shift register (multiplier).
REQ-007 load  output  1  parallel-load strobe to both upstream shift registers.
REQ-008 shift  output  1  shift-enable strobe to both upstream shift registers.
REQ-009 product  output  2*WORD_LENGTH  accumulated product, registered.
REQ-010 ready  output  1  high in IDLE; a start is accepted only while ready is high.
REQ-011 done  output  1  one-cycle pulse; product is final while done is high.

Function
REQ-012 The FSM SHALL have four states: IDLE, LOAD, ACCUM and DONE.
REQ-013 In IDLE with start=1 at an edge: go to LOAD and clear product to 0; with start=0: stay in IDLE with product held.
REQ-014 LOAD: load=1 and shift=0 for exactly one cycle; the bit counter is cleared to 0; go to ACCUM.
REQ-015 ACCUM: shift=1 and load=0 every cycle; at each edge, if multiplierBit=1 then product <= product + multiplicandShifted, else product is held.
REQ-016 ACCUM: the bit counter increments at each edge; after exactly WORD_LENGTH ACCUM cycles (counter = WORD_LENGTH-1 at the edge) go to DONE.
REQ-017 DONE: done=1 and shift=0 for one cycle; go to IDLE; product is held.
REQ-018 Latency: with start sampled at edge 0, done SHALL be high in cycle WORD_LENGTH+2 (LOAD in cycle 1, ACCUM in cycles 2..WORD_LENGTH+1).
REQ-019 Addition SHALL be unsigned modulo 2^(2*WORD_LENGTH); for unsigned operands no overflow can occur.
REQ-020 load, shift, ready and done SHALL be Moore outputs decoded from state only; at most one of load and shift is high in any cycle.
REQ-021 start SHALL be ignored in LOAD, ACCUM and DONE.
REQ-022 If start is held high continuously, each multiplication SHALL be separated by exactly one IDLE cycle.
REQ-023 product SHALL retain its last value from DONE until the next accepted start.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, counter=0, product=0, load=0, shift=0, done=0 and ready=1, including mid-operation.
REQ-025 After reset is released, the first edge SHALL behave as IDLE.

Structure
REQ-026 A shared package multiplier_pkg SHALL hold the FSM state enum, the default WORD_LENGTH, and the counter-width constant (clog2 of WORD_LENGTH).
REQ-027 The bit counter SHALL be a separate sub-module, bit_counter, with clear, enable and terminal-count outputs.
REQ-028 The accumulator register and FSM SHALL reside in shift_add_accumulator; the block SHALL contain no internal copy of the operand shift registers.

Verification
The bench SHALL model both upstream shift registers behaviourally, driven by load and shift.
REQ-029 170 x 170 with WORD_LENGTH=8 -> done in cycle 10 after the start edge, product=28900.
REQ-030 255 x 255 -> product=65025; 0 x 200 -> product=0 and 200 x 0 -> product=0.
REQ-031 start pulsed again during ACCUM -> ignored; the first result is unchanged and ready stays low until after DONE.
REQ-032 start held high for three operations (3x5, 7x9, 1x1) -> products 15, 63 and 1, with one IDLE cycle between each done and the following LOAD.
REQ-033 reset=0 asserted in the 4th ACCUM cycle -> outputs reach their reset values immediately, without a clock edge; a following 12x12 run gives product=144.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared types and sizing for the shift-add multiplier datapath.
package multiplier_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ACCUM = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int DEFAULT_WORD_LENGTH = 8;

   // A one-bit operand still needs a one-bit counter, which $clog2(1) would not give.
   function automatic int counter_width(input int wl);
      return (wl > 1) ? $clog2(wl) : 1;
   endfunction

   localparam int COUNTER_WIDTH = counter_width(DEFAULT_WORD_LENGTH);

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter with synchronous clear, enable and a terminal flag.
// Terminal is decoded from the held count, so it is valid in the cycle the last bit is consumed.
module bit_counter
   import multiplier_pkg::*;
#(
   parameter int                 WIDTH    = COUNTER_WIDTH,
   parameter logic [WIDTH-1:0]   TERMINAL = '1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

   assign terminal = (count == TERMINAL);

endmodule

// File: rtl/shift_add_accumulator.sv
// Shift-add multiplier control and accumulator; operands come from external shift registers.
// Result after WORD_LENGTH+2 cycles from start; start is only accepted while ready (IDLE).
module shift_add_accumulator
   import multiplier_pkg::*;
#(
   parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [2*WORD_LENGTH-1:0]   multiplicandShifted,
   input  logic                       multiplierBit,
   output logic                       load,
   output logic                       shift,
   output logic [2*WORD_LENGTH-1:0]   product,
   output logic                       ready,
   output logic                       done
);

   localparam int            CW   = counter_width(WORD_LENGTH);
   localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

   state_t state;
   state_t state_nxt;
   logic   cnt_last;

   bit_counter #(
      .WIDTH    (CW),
      .TERMINAL (LAST)
   ) u_bit_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (load),
      .enable   (shift),
      .terminal (cnt_last)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_ACCUM;
         S_ACCUM: if (cnt_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Product is cleared on acceptance so the last result stays visible while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         product <= '0;
      end else if (state == S_IDLE && start) begin
         product <= '0;
      end else if (state == S_ACCUM && multiplierBit) begin
         product <= product + multiplicandShifted;
      end
   end

   assign ready = (state == S_IDLE);
   assign load  = (state == S_LOAD);
   assign shift = (state == S_ACCUM);
   assign done  = (state == S_DONE);

endmodule

// File: tb/tb_shift_add_accumulator.sv
// Directed bench for shift_add_accumulator with behavioural upstream shift registers.
module tb_shift_add_accumulator;

   localparam int WL = 8;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [2*WL-1:0] mcand_sr;
   logic [WL-1:0]   mplier_sr;
   logic            load;
   logic            shift;
   logic [2*WL-1:0] product;
   logic            ready;
   logic            done;

   logic [WL-1:0]   op_a;
   logic [WL-1:0]   op_b;
   int              total;
   int              bad;

   shift_add_accumulator #(.WORD_LENGTH(WL)) dut (
      .clk                 (clk),
      .reset               (rst_n),
      .start               (start),
      .multiplicandShifted (mcand_sr),
      .multiplierBit       (mplier_sr[0]),
      .load                (load),
      .shift               (shift),
      .product             (product),
      .ready               (ready),
      .done                (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream registers: multiplicand shifts left, multiplier shifts right.
   always @(posedge clk) begin
      if (load) begin
         mcand_sr  <= {{WL{1'b0}}, op_a};
         mplier_sr <= op_b;
      end else if (shift) begin
         mcand_sr  <= mcand_sr << 1;
         mplier_sr <= mplier_sr >> 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic run_op(input logic [WL-1:0] a, input logic [WL-1:0] b,
                         input logic [2*WL-1:0] exp, input string tag);
      int n;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_load"}, 32'(load), 32'd1);
      wait_done(n);
      chk({tag, "_latency"}, 32'(n + 1), 32'(WL + 2));
      chk({tag, "_product"}, 32'(product), 32'(exp));
      @(negedge clk);
      chk({tag, "_ready_after"}, 32'(ready), 32'd1);
      chk({tag, "_held"}, 32'(product), 32'(exp));
   endtask

   initial begin
      int n;
      logic [WL-1:0]   seq_a [3];
      logic [WL-1:0]   seq_b [3];
      logic [2*WL-1:0] seq_p [3];

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_load_shift_done", 32'({load, shift, done}), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_start", 32'({ready, load}), 32'b10);

      run_op(8'd170, 8'd170, 16'd28900, "m170x170");
      run_op(8'd255, 8'd255, 16'd65025, "m255x255");
      run_op(8'd0,   8'd200, 16'd0,     "m0x200");
      run_op(8'd200, 8'd0,   16'd0,     "m200x0");

      // Start pulse during ACCUM must be ignored.
      op_a  = 8'd170;
      op_b  = 8'd170;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("ign_in_accum", 32'(shift), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_ready_low", 32'(ready), 32'd0);
      wait_done(n);
      chk("ign_latency", 32'(n + 5), 32'd10);
      chk("ign_product", 32'(product), 32'd28900);
      @(negedge clk);
      chk("ign_no_restart", 32'({ready, load}), 32'b10);
      @(negedge clk);
      chk("ign_still_idle", 32'({ready, load}), 32'b10);

      // Start held high across three back-to-back operations.
      seq_a = '{8'd3, 8'd7, 8'd1};
      seq_b = '{8'd5, 8'd9, 8'd1};
      seq_p = '{16'd15, 16'd63, 16'd1};
      op_a  = seq_a[0];
      op_b  = seq_b[0];
      start = 1'b1;
      @(negedge clk);
      chk("hold0_load", 32'(load), 32'd1);
      for (int i = 0; i < 3; i++) begin
         wait_done(n);
         chk($sformatf("hold%0d_latency", i), 32'(n + 1), 32'd10);
         chk($sformatf("hold%0d_product", i), 32'(product), 32'(seq_p[i]));
         if (i < 2) begin
            op_a = seq_a[i + 1];
            op_b = seq_b[i + 1];
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("hold%0d_gap_idle", i), 32'({ready, load}), 32'b10);
         if (i < 2) begin
            @(negedge clk);
            chk($sformatf("hold%0d_next_load", i), 32'(load), 32'd1);
         end
      end

      // Asynchronous reset in the 4th ACCUM cycle.
      op_a  = 8'd170;
      op_b  = 8'd170;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_shift", 32'(shift), 32'd1);
      chk("pre_rst_product", 32'(product), 32'd340);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", 32'(ready), 32'd1);
      chk("arst_load_shift_done", 32'({load, shift, done}), 32'd0);
      chk("arst_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 32'({ready, load}), 32'b10);
      run_op(8'd12, 8'd12, 16'd144, "m12x12");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
